// File: rtl/a1000_clock_reset.sv
// a1000_clock_reset: A1000 clock phase generator and system reset sequencer.
//   CLK_28M  in   master clock, the only clock
//   reset    in   asynchronous active-high reset
//   _KBRST   in   active-low keyboard reset request, asynchronous
//   C7M      out  7.16 MHz phase
//   CDAC     out  7.16 MHz, one CLK_28M period behind C7M
//   _C1      out  3.58 MHz system clock
//   _C3      out  3.58 MHz, two CLK_28M periods behind _C1
//   _RST     out  active-low system reset, held RST_CYCLES _C1 periods
//   c1_rise  out  one-cycle strobe after each _C1 rising edge
module a1000_clock_reset #(
  parameter int unsigned RST_CYCLES = 64
) (
  input  logic CLK_28M,
  input  logic reset,
  input  logic _KBRST,
  output logic C7M,
  output logic CDAC,
  output logic _C1,
  output logic _C3,
  output logic _RST,
  output logic c1_rise
);
  localparam logic [7:0] RC = 8'(RST_CYCLES);
  logic [2:0] ph;
  logic [2:0] ph_n;
  logic [7:0] cnt;
  logic       kb_m;
  logic       kb_s;
  logic       wrap;
  assign ph_n = ph + 3'd1;
  assign wrap = ph == 3'd7;
  // Clock outputs are registered from the next phase so each is a clean flop output.
  // The keyboard load wins over a wrap decrement on the same edge, restarting the full hold.
  always_ff @(posedge CLK_28M or posedge reset)
    if (reset) begin
      ph      <= 3'd0;
      C7M     <= 1'b1;
      CDAC    <= 1'b0;
      _C1     <= 1'b1;
      _C3     <= 1'b0;
      c1_rise <= 1'b0;
      _RST    <= 1'b0;
      cnt     <= RC;
      kb_m    <= 1'b1;
      kb_s    <= 1'b1;
    end else begin
      ph      <= ph_n;
      C7M     <= ~ph_n[1];
      CDAC    <= ph_n[0] ^ ph_n[1];
      _C1     <= ~ph_n[2];
      _C3     <= ph_n[2] ^ ph_n[1];
      c1_rise <= wrap;
      kb_m    <= _KBRST;
      kb_s    <= kb_m;
      cnt     <= !kb_s ? RC : (wrap && cnt != 8'd0) ? cnt - 8'd1 : cnt;
      _RST    <= !kb_s ? 1'b0 : (wrap && cnt == 8'd1) ? 1'b1 : _RST;
    end
endmodule

// File: doc/a1000_clock_reset.md
A1000_CLOCK_RESET -- requirements
Module: a1000_clock_reset

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 64: number of _C1 periods _RST is held low after a reset source is released; legal range 1..255.
REQ-002 SHALL have port CLK_28M  input  1  master clock (28.636 MHz); the only clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port _KBRST  input  1  active-low keyboard reset request, asynchronous to CLK_28M.
REQ-005 SHALL have port C7M  output  1  7.16 MHz clock phase.
REQ-006 SHALL have port CDAC  output  1  7.16 MHz clock, lagging C7M by one CLK_28M period.
REQ-007 SHALL have port _C1  output  1  3.58 MHz clock phase, the clock that feeds the A1000 system.
REQ-008 SHALL have port _C3  output  1  3.58 MHz clock, lagging _C1 by two CLK_28M periods.
REQ-009 SHALL have port _RST  output  1  active-low system reset to the A1000.
REQ-010 SHALL have port c1_rise  output  1  single-cycle strobe, high for the CLK_28M cycle following each _C1 rising edge.

Function
REQ-011 SHALL keep a 3-bit phase counter ph that increments by 1 modulo 8 on every CLK_28M edge, including while _RST is low.
REQ-012 SHALL drive every clock output from a flop, so that after each edge: C7M = ~ph[1]; CDAC = ph[0]^ph[1]; _C1 = ~ph[2]; _C3 = (ph in 2..5).
REQ-013 SHALL produce no glitches on any output; each output changes at most once per CLK_28M period.
REQ-014 SHALL assert c1_rise for exactly the cycle in which ph = 0 after a 7->0 wrap, and SHALL NOT assert it on the reset value.
REQ-015 SHALL synchronise _KBRST through two CLK_28M flops (kb_s) before any use.
REQ-016 SHALL hold an 8-bit hold counter cnt, decremented on each ph 7->0 wrap while cnt > 0, and saturating at 0.
REQ-017 SHALL set _RST high on the edge on which cnt decrements from 1 to 0; _RST stays high while cnt = 0 and kb_s = 1.
REQ-018 SHALL, on any edge with kb_s = 0, load cnt <= RST_CYCLES and drive _RST <= 0 on that same edge; the load SHALL take priority over a simultaneous wrap decrement.
REQ-019 SHALL leave the phase counter and clock outputs unaffected by _KBRST.
REQ-020 SHALL restart the full RST_CYCLES hold if _KBRST is re-asserted during a hold; there SHALL be no partial credit.

Reset
REQ-021 SHALL, while reset = 1 and independent of the clock, force: ph = 0, C7M = 1, CDAC = 0, _C1 = 1, _C3 = 0, c1_rise = 0, _RST = 0, cnt = RST_CYCLES, sync flops = 1.
REQ-022 SHALL treat reset asserted mid-hold or mid-phase identically to power-on: the full hold restarts and ph restarts at 0.
REQ-023 SHALL, on the first edge after reset is released, advance ph to 1, with no extra dead cycle.

Verification
REQ-024 Clock phasing: release reset, run 16 edges -> C7M pattern 1,1,0,0 repeating; CDAC 0,1,1,0 repeating; _C1 1×4, 0×4; _C3 0,0,1,1,1,1,0,0; period 8.
REQ-025 Power-on hold: RST_CYCLES = 4, _KBRST = 1, release reset -> _RST = 0 through edge 31 and goes high on edge 32; c1_rise is high after edges 8, 16, 24 and 32.
REQ-026 Keyboard reset: after _RST goes high, drive _KBRST low before edge N -> _RST falls at edge N+2; hold _KBRST low for 20 edges, then release -> _RST rises exactly RST_CYCLES wraps after the last edge with kb_s = 0.
REQ-027 Re-trigger collision: pulse kb_s low on the same edge as the wrap where cnt = 1 -> _RST stays low and cnt = RST_CYCLES.
REQ-028 Async reset mid-hold: assert reset between edges while cnt = 2 -> outputs take their REQ-021 values immediately; after release, the full 32-edge hold (RST_CYCLES = 4) repeats.
REQ-029 Parameter extreme: RST_CYCLES = 1 -> _RST rises on edge 8; RST_CYCLES = 255 -> _RST rises on edge 2040.
